// File: rtl/icache_data_array.sv
// Instruction-cache data store: WAYS x SETS lines of LINE_WORDS words, parallel way read,
// critical-word-first refill sequencer. Define ICACHE_DATA_PARITY_EN for per-word even parity.
module icache_data_array #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_index,
    input  logic [OFF_W-1:0]         rd_offset,
    output logic [WAYS*DATA_W-1:0]   rd_data,
    output logic                     rd_valid,
    output logic [WAYS-1:0]          rd_perr,
    input  logic                     fill_start,
    input  logic [WAY_W-1:0]         fill_way,
    input  logic [IDX_W-1:0]         fill_index,
    input  logic [OFF_W-1:0]         fill_offset,
    input  logic                     fill_valid,
    input  logic [DATA_W-1:0]        fill_data,
    input  logic                     fill_last,
    output logic                     fill_ready,
    output logic                     fill_busy,
    output logic [LINE_WORDS-1:0]    fill_word_vld,
    output logic                     fill_done,
    output logic                     fill_err
);

    localparam int ADDR_W = WAY_W + IDX_W + OFF_W;
    localparam int DEPTH  = WAYS * SETS * LINE_WORDS;
`ifdef ICACHE_DATA_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [WAY_W-1:0]        way_reg;
    logic [IDX_W-1:0]        index_reg;
    logic [OFF_W-1:0]        off_reg;
    logic [OFF_W-1:0]        cnt_reg;
    logic [LINE_WORDS-1:0]   word_vld_reg;
    logic                    err_reg;
    logic                    rd_valid_reg;
    logic                    beat;
    logic                    last_beat;
    logic [ADDR_W-1:0]       wr_addr;
    logic [STORE_W-1:0]      wr_word;

    logic [STORE_W-1:0] mem [DEPTH];

    assign beat      = (state_reg == S_FILL) && fill_valid;
    assign last_beat = (cnt_reg == '1);
    assign wr_addr   = {way_reg, index_reg, off_reg};
`ifdef ICACHE_DATA_PARITY_EN
    assign wr_word   = {^fill_data, fill_data};
`else
    assign wr_word   = fill_data;
`endif

    // State register plus the refill bookkeeping that moves with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            way_reg      <= '0;
            index_reg    <= '0;
            off_reg      <= '0;
            cnt_reg      <= '0;
            word_vld_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Flags both an early fill_last and a final beat missing fill_last
            err_reg   <= beat && (fill_last != last_beat);
            if (state_reg == S_IDLE && fill_start) begin
                way_reg      <= fill_way;
                index_reg    <= fill_index;
                off_reg      <= fill_offset;
                cnt_reg      <= '0;
                word_vld_reg <= '0;
            end else if (beat) begin
                off_reg               <= off_reg + 1'b1;
                cnt_reg               <= cnt_reg + 1'b1;
                word_vld_reg[off_reg] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (fill_start) state_next = S_FILL;
            S_FILL: begin
                if (beat) begin
                    if (last_beat)      state_next = S_DONE;
                    else if (fill_last) state_next = S_IDLE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fill_ready = (state_reg == S_FILL);
        fill_busy  = (state_reg != S_IDLE);
        fill_done  = (state_reg == S_DONE);
    end

    assign fill_err      = err_reg;
    assign fill_word_vld = word_vld_reg;

    // Storage is not reset; validity is tracked by the tag side
    always_ff @(posedge clk) begin
        if (beat) mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_valid_reg <= 1'b0;
        else     rd_valid_reg <= rd_en;
    end
    assign rd_valid = rd_valid_reg;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [ADDR_W-1:0]  rd_addr;
            logic [STORE_W-1:0] raw_word;
            logic               fwd;
            logic [DATA_W-1:0]  lane_reg;

            assign rd_addr  = {WAY_W'(gi), rd_index, rd_offset};
            assign raw_word = mem[rd_addr];
            // Write-first: a beat landing on the word being read wins over the old contents
            assign fwd = beat && (way_reg == WAY_W'(gi)) &&
                         (index_reg == rd_index) && (off_reg == rd_offset);

            always_ff @(posedge clk) begin
                if (rst)        lane_reg <= '0;
                else if (rd_en) lane_reg <= fwd ? fill_data : raw_word[DATA_W-1:0];
            end
            assign rd_data[gi*DATA_W +: DATA_W] = lane_reg;

`ifdef ICACHE_DATA_PARITY_EN
            logic perr_reg;
            always_ff @(posedge clk) begin
                if (rst)        perr_reg <= 1'b0;
                else if (rd_en) perr_reg <= fwd ? 1'b0 : ^raw_word;
            end
            assign rd_perr[gi] = perr_reg;
`endif
        end
    endgenerate

`ifndef ICACHE_DATA_PARITY_EN
    assign rd_perr = '0;
`endif

endmodule

// File: tb/tb_icache_data_array.sv
// Self-checking bench for icache_data_array: directed fill/read scenarios plus randomized
// fills with concurrent reads against an array model of the line store.
module tb_icache_data_array;
    localparam int WAYS = 2;
    localparam int SETS = 128;
    localparam int LW   = 8;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_en = 1'b0;
    logic [6:0]        rd_index = '0;
    logic [2:0]        rd_offset = '0;
    logic [WAYS*DW-1:0] rd_data;
    logic              rd_valid;
    logic [WAYS-1:0]   rd_perr;
    logic              fill_start = 1'b0;
    logic [0:0]        fill_way = '0;
    logic [6:0]        fill_index = '0;
    logic [2:0]        fill_offset = '0;
    logic              fill_valid = 1'b0;
    logic [DW-1:0]     fill_data = '0;
    logic              fill_last = 1'b0;
    logic              fill_ready;
    logic              fill_busy;
    logic [LW-1:0]     fill_word_vld;
    logic              fill_done;
    logic              fill_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_data  [WAYS][SETS][LW];
    bit            m_known [WAYS][SETS][LW];

    icache_data_array dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_perr(rd_perr),
        .fill_start(fill_start), .fill_way(fill_way), .fill_index(fill_index),
        .fill_offset(fill_offset), .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_last(fill_last), .fill_ready(fill_ready), .fill_busy(fill_busy),
        .fill_word_vld(fill_word_vld), .fill_done(fill_done), .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input int w);
        return rd_data[w*DW +: DW];
    endfunction

    task automatic read_word(input int idx, input int off);
        rd_en = 1'b1; rd_index = 7'(idx); rd_offset = 3'(off);
        tick;
        rd_en = 1'b0;
    endtask

    // Drives one refill (optional idle gaps), updates the model, and tallies pulses seen
    task automatic fill_seq(input int way, input int idx, input int off, input int nbeats,
                            input int last_k, input int tail,
                            output int done_cnt, output int err_cnt);
        int cur;
        logic [DW-1:0] d;
        cur = off; done_cnt = 0; err_cnt = 0;
        fill_start = 1'b1; fill_way = 1'(way); fill_index = 7'(idx); fill_offset = 3'(off);
        tick;
        fill_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                fill_valid = 1'b0;
                tick;
                done_cnt += int'(fill_done); err_cnt += int'(fill_err);
            end
            d = $urandom;
            fill_valid = 1'b1; fill_data = d; fill_last = (k == last_k);
            tick;
            done_cnt += int'(fill_done); err_cnt += int'(fill_err);
            m_data[way][idx][cur] = d; m_known[way][idx][cur] = 1'b1;
            cur = (cur + 1) % LW;
        end
        fill_valid = 1'b0; fill_last = 1'b0;
        for (int t = 0; t < tail; t++) begin
            tick;
            done_cnt += int'(fill_done); err_cnt += int'(fill_err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_perr !== '0) begin errors++; $display("FAIL reset_rd_perr: got %b expected 0", rd_perr); end
        checks++; if ({fill_ready, fill_busy, fill_done, fill_err} !== 4'b0) begin
            errors++; $display("FAIL reset_fill_flags: got %b expected 0000", {fill_ready, fill_busy, fill_done, fill_err}); end
        checks++; if (fill_word_vld !== '0) begin errors++; $display("FAIL reset_word_vld: got %b expected 0", fill_word_vld); end
        rd_index = 7'd5; rd_offset = 3'd0;
        tick;
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++; $display("FAIL idle_read: valid %b data %h expected 0/0", rd_valid, rd_data); end
        read_word(5, 0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL first_read_valid: got %b expected 1", rd_valid); end
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b expected 0", rd_valid); end
    endtask

    task automatic test_wrap_fill;
        int cur;
        cur = 6;
        fill_start = 1'b1; fill_way = 1'b1; fill_index = 7'd3; fill_offset = 3'd6;
        tick;
        fill_start = 1'b0;
        checks++; if (fill_ready !== 1'b1 || fill_busy !== 1'b1) begin
            errors++; $display("FAIL wrap_start: ready %b busy %b expected 1/1", fill_ready, fill_busy); end
        for (int i = 0; i < 8; i++) begin
            fill_valid = 1'b1; fill_data = 32'hA0 + 32'(i); fill_last = (i == 7);
            tick;
            m_data[1][3][cur] = 32'hA0 + 32'(i); m_known[1][3][cur] = 1'b1;
            cur = (cur + 1) % LW;
            if (i == 2) begin
                checks++; if (fill_word_vld !== 8'b11000001) begin
                    errors++; $display("FAIL wrap_word_vld_beat3: got %b expected 11000001", fill_word_vld); end
            end
            if (i < 7) begin
                checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL wrap_early_done: beat %0d done %b expected 0", i, fill_done); end
            end
        end
        fill_valid = 1'b0; fill_last = 1'b0;
        checks++; if (fill_done !== 1'b1 || fill_err !== 1'b0) begin
            errors++; $display("FAIL wrap_done: done %b err %b expected 1/0", fill_done, fill_err); end
        tick;
        checks++; if (fill_done !== 1'b0 || fill_busy !== 1'b0 || fill_word_vld !== 8'hFF) begin
            errors++; $display("FAIL wrap_after: done %b busy %b vld %b expected 0/0/11111111", fill_done, fill_busy, fill_word_vld); end
        read_word(3, 0);
        checks++; if (lane(1) !== 32'hA2) begin errors++; $display("FAIL wrap_read_off0: got %h expected a2", lane(1)); end
        for (int o = 1; o < LW; o++) begin
            read_word(3, o);
            checks++; if (lane(1) !== m_data[1][3][o]) begin
                errors++; $display("FAIL wrap_read off %0d: got %h expected %h", o, lane(1), m_data[1][3][o]); end
        end
    endtask

    task automatic test_forwarding;
        int dc, ec, cur;
        fill_seq(1, 2, 0, 8, 7, 2, dc, ec);
        checks++; if (dc != 1 || ec != 0) begin errors++; $display("FAIL fwd_prefill: done %0d err %0d expected 1/0", dc, ec); end
        fill_start = 1'b1; fill_way = 1'b0; fill_index = 7'd2; fill_offset = 3'd4;
        tick;
        fill_start = 1'b0;
        fill_valid = 1'b1; fill_data = 32'h1234; fill_last = 1'b0;
        rd_en = 1'b1; rd_index = 7'd2; rd_offset = 3'd4;
        tick;
        rd_en = 1'b0;
        m_data[0][2][4] = 32'h1234; m_known[0][2][4] = 1'b1;
        checks++; if (lane(0) !== 32'h1234) begin errors++; $display("FAIL fwd_way0: got %h expected 1234", lane(0)); end
        checks++; if (lane(1) !== m_data[1][2][4]) begin errors++; $display("FAIL fwd_way1: got %h expected %h", lane(1), m_data[1][2][4]); end
        checks++; if (rd_perr !== '0) begin errors++; $display("FAIL fwd_perr: got %b expected 0", rd_perr); end
        cur = 5;
        for (int k = 1; k < 8; k++) begin
            fill_data = $urandom; fill_last = (k == 7);
            m_data[0][2][cur] = fill_data; m_known[0][2][cur] = 1'b1;
            cur = (cur + 1) % LW;
            tick;
        end
        fill_valid = 1'b0; fill_last = 1'b0;
        checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL fwd_fill_done: got %b expected 1", fill_done); end
        tick;
    endtask

    task automatic test_early_last;
        int dc, ec;
        fill_seq(0, 9, 2, 3, 2, 0, dc, ec);
        checks++; if (fill_err !== 1'b1 || fill_busy !== 1'b0) begin
            errors++; $display("FAIL early_err_pulse: err %b busy %b expected 1/0", fill_err, fill_busy); end
        tick;
        checks++; if (fill_err !== 1'b0 || fill_done !== 1'b0 || dc != 0) begin
            errors++; $display("FAIL early_after: err %b done %b done_cnt %0d expected 0/0/0", fill_err, fill_done, dc); end
        fill_seq(0, 9, 5, 8, 7, 2, dc, ec);
        checks++; if (dc != 1 || ec != 0) begin errors++; $display("FAIL early_refill: done %0d err %0d expected 1/0", dc, ec); end
        for (int o = 0; o < LW; o += 3) begin
            read_word(9, o);
            checks++; if (lane(0) !== m_data[0][9][o]) begin
                errors++; $display("FAIL early_readback off %0d: got %h expected %h", o, lane(0), m_data[0][9][o]); end
        end
    endtask

    task automatic test_reset_mid_fill;
        int dc, ec, o;
        fill_seq(1, 20, 5, 4, -1, 0, dc, ec);
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", fill_busy); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (fill_busy !== 1'b0 || fill_done !== 1'b0 || fill_err !== 1'b0 || fill_word_vld !== '0) begin
            errors++; $display("FAIL midrst_state: busy %b done %b err %b vld %b expected 0/0/0/0", fill_busy, fill_done, fill_err, fill_word_vld); end
        tick;
        checks++; if (fill_done !== 1'b0 || dc != 0) begin errors++; $display("FAIL midrst_done: got %b cnt %0d expected 0", fill_done, dc); end
        for (int k = 0; k < 4; k++) begin
            o = (5 + k) % LW;
            read_word(20, o);
            checks++; if (lane(1) !== m_data[1][20][o]) begin
                errors++; $display("FAIL midrst_readback off %0d: got %h expected %h", o, lane(1), m_data[1][20][o]); end
        end
    endtask

    task automatic test_random;
        int way, idx, cur, k;
        bit miss, do_beat, do_rd;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_lane [WAYS];
        bit            exp_known [WAYS];
        for (int w = 0; w < WAYS; w++) begin exp_known[w] = 1'b0; exp_lane[w] = '0; end
        for (int f = 0; f < 8; f++) begin
            way = $urandom_range(0, 1); idx = $urandom_range(0, 3); cur = $urandom_range(0, 7);
            miss = (f % 3 == 2);
            fill_start = 1'b1; fill_way = 1'(way); fill_index = 7'(idx); fill_offset = 3'(cur);
            tick;
            fill_start = 1'b0;
            k = 0;
            while (k < LW) begin
                do_beat = ($urandom_range(0, 3) != 0);
                do_rd   = $urandom_range(0, 1) == 1;
                d = $urandom;
                fill_valid = do_beat; fill_data = d; fill_last = do_beat && !miss && (k == LW - 1);
                rd_en = do_rd; rd_index = 7'($urandom_range(0, 3)); rd_offset = 3'($urandom_range(0, 7));
                if (do_beat) begin m_data[way][idx][cur] = d; m_known[way][idx][cur] = 1'b1; end
                if (do_rd) begin
                    for (int w = 0; w < WAYS; w++) begin
                        exp_known[w] = m_known[w][rd_index][rd_offset];
                        exp_lane[w]  = m_data[w][rd_index][rd_offset];
                    end
                end
                tick;
                checks++; if (rd_valid !== do_rd) begin errors++; $display("FAIL rand_valid: got %b expected %b", rd_valid, do_rd); end
                for (int w = 0; w < WAYS; w++) begin
                    if (exp_known[w]) begin
                        checks++; if (lane(w) !== exp_lane[w]) begin
                            errors++; $display("FAIL rand_lane%0d: got %h expected %h", w, lane(w), exp_lane[w]); end
                    end
                end
                checks++; if (rd_perr !== '0) begin errors++; $display("FAIL rand_perr: got %b expected 0", rd_perr); end
                if (do_beat) begin cur = (cur + 1) % LW; k++; end
            end
            fill_valid = 1'b0; fill_last = 1'b0; rd_en = 1'b0;
            checks++; if (fill_done !== 1'b1 || fill_err !== miss) begin
                errors++; $display("FAIL rand_done fill %0d: done %b err %b expected 1/%b", f, fill_done, fill_err, miss); end
            tick;
        end
    endtask

    task automatic test_parity;
        int dc, ec;
        fill_seq(0, 7, 0, 8, 7, 1, dc, ec);
        fill_seq(1, 7, 3, 8, 7, 1, dc, ec);
`ifdef ICACHE_DATA_PARITY_EN
        dut.mem[57] = dut.mem[57] ^ 33'h20;
        read_word(7, 1);
        checks++; if (rd_perr !== 2'b01) begin errors++; $display("FAIL parity_corrupt: got %b expected 01", rd_perr); end
`else
        read_word(7, 1);
        checks++; if (rd_perr !== 2'b00) begin errors++; $display("FAIL parity_off: got %b expected 00", rd_perr); end
        checks++; if (lane(0) !== m_data[0][7][1]) begin errors++; $display("FAIL parity_off_data: got %h expected %h", lane(0), m_data[0][7][1]); end
`endif
    endtask

    initial begin
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                for (int o = 0; o < LW; o++) begin
                    m_known[w][s][o] = 1'b0;
                    m_data[w][s][o]  = '0;
                end
        test_reset;
        test_wrap_fill;
        test_forwarding;
        test_early_last;
        test_reset_mid_fill;
        test_random;
        test_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
